rx_port_scheduler: RTL and testbench
====================================

// Module: rx_port_scheduler
// PURPOSE
//  Round-robin scheduler sharing one forwarding engine between NUM_PORTS ingress packet
//  buffers. Each buffer raises buf_ready when it holds a complete packet. The scheduler
//  grants one port, starts the engine, waits for completion (with timeout) and then pulses
//  that buffer's flush to re-arm it. Sits between the per-port AXIS ingress buffers and the
//  lookup/forward engine.
// PARAMETERS
//  NUM_PORTS      4     number of ingress buffers (>=2)
//  PORT_IDX_W     2     width of port index, = clog2(NUM_PORTS)
//  TIMEOUT_CYCLES 4096  max WAIT_DONE cycles before packet is dropped (>=2)
//  TIMEOUT_W      13    counter width, holds TIMEOUT_CYCLES-1
// PORTS
//  aclk         in   1           clock, all logic rising-edge
//  aresetn      in   1           reset, asynchronous, active-low
//  port_enable  in   NUM_PORTS   per-port arbitration mask (1 = eligible)
//  buf_ready    in   NUM_PORTS   buffer i holds complete packet
//  buf_flush    out  NUM_PORTS   one-cycle pulse releasing buffer i (one-hot or zero)
//  eng_start    out  1           one-cycle pulse: engine begins on eng_port
//  eng_port     out  PORT_IDX_W  granted port, stable from GRANT through RELEASE
//  eng_done     in   1           engine finished current packet (sampled in WAIT_DONE only)
//  busy         out  1           high in any state other than IDLE
//  timeout_err  out  1           one-cycle pulse when a packet is dropped on timeout
//  drop_cnt     out  16          saturating count of timeouts
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, buf_flush=0, eng_start=0, eng_port=0,
//   busy=0, timeout_err=0, drop_cnt=0, last_grant=NUM_PORTS-1 (port 0 wins first).
//  Request vector req = buf_ready & port_enable.
//  FSM:
//   IDLE: if req!=0 -> GRANT; winner = first set bit of req searching last_grant+1 upward,
//         wrapping NUM_PORTS-1 -> 0; eng_port<=winner, last_grant<=winner. Else stay.
//   GRANT: eng_start=1 (exactly one cycle); timer<=0 -> WAIT_DONE.
//   WAIT_DONE: eng_done -> FLUSH. Else if timer==TIMEOUT_CYCLES-1 -> FLUSH with
//         timeout_err pulse, drop_cnt+1 (saturate at 16'hFFFF). Else timer+1.
//         eng_done and timeout in same cycle: done wins, no error.
//   FLUSH: buf_flush[eng_port]=1 for exactly one cycle -> RELEASE.
//   RELEASE: one dead cycle (buffer ready deasserts) -> IDLE. No arbitration here.
//  Latency: req seen at edge N -> eng_start high cycle N+1; eng_done at edge M ->
//   buf_flush high cycle M+1; earliest next eng_start at M+4.
//  Minimum turnaround per packet = 5 cycles (IDLE,GRANT,WAIT_DONE,FLUSH,RELEASE).
//  port_enable/buf_ready changes affect only IDLE arbitration; an in-flight grant
//   completes even if its port is disabled or its buf_ready drops.
//  eng_done outside WAIT_DONE is ignored. eng_port never changes outside IDLE->GRANT.
//  Single-requester case: same port re-granted every turnaround (no starvation of others
//   since search always starts after last_grant).
//  Reset asserted mid-packet: all outputs return to reset values immediately; no flush
//   pulse is issued; buffers are re-armed by their own reset.
// STRUCTURE
//  Shared package router_pkg: state encoding (IDLE,GRANT,WAIT_DONE,FLUSH,RELEASE),
//   PORT_IDX_W derivation helper, DROP_CNT_W=16.
//  Sub-module rr_arbiter (NUM_PORTS): inputs req, last_grant; outputs winner index and
//   any_req; purely combinational rotate/priority-encode/unrotate. FSM, timer and
//   counters live in rx_port_scheduler.
// TESTING
//  1 Reset, buf_ready=4'b0001, enable=all -> eng_start cycle 1, eng_port=0; eng_done 3
//    cycles later -> buf_flush=4'b0001 next cycle, busy low 2 cycles after.
//  2 buf_ready=4'b1111 held, eng_done 1 cycle after each start -> grant order 0,1,2,3,0
//    and eng_start spacing of 5 cycles.
//  3 TIMEOUT_CYCLES=8, no eng_done -> timeout_err pulse on 8th WAIT_DONE cycle,
//    buf_flush pulse next cycle, drop_cnt=1; repeat 3x -> drop_cnt=3.
//  4 eng_done coincident with timer==TIMEOUT_CYCLES-1 -> no timeout_err, drop_cnt unchanged.
//  5 port_enable=4'b1011 with buf_ready=4'b0110 -> only port 1 granted; clear enable[1]
//    mid WAIT_DONE -> packet still completes and flushes port 1.
//  6 aresetn low during WAIT_DONE -> outputs zero asynchronously, no buf_flush; after
//    release with buf_ready=4'b0100 -> first grant port 2.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the ingress-to-engine scheduling path.
package router_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StWaitDone,
    StFlush,
    StRelease
  } state_e;

  localparam int unsigned DROP_CNT_W = 16;

  function automatic int unsigned port_idx_width(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned PORT_IDX_W = 2
) (
  input  logic [NUM_PORTS-1:0]  req_i,
  input  logic [PORT_IDX_W-1:0] last_grant_i,
  output logic [PORT_IDX_W-1:0] winner_o,
  output logic                  any_req_o
);

  logic                  hi_any;
  logic [PORT_IDX_W-1:0] hi_win;
  logic [PORT_IDX_W-1:0] lo_win;

  // Equivalent to rotate/priority-encode/unrotate: lowest requester above last_grant,
  // otherwise lowest requester overall (the wrapped half).
  always_comb begin
    hi_any = 1'b0;
    hi_win = '0;
    lo_win = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_win = PORT_IDX_W'(i);
        if (i > int'(last_grant_i)) begin
          hi_any = 1'b1;
          hi_win = PORT_IDX_W'(i);
        end
      end
    end
  end

  assign winner_o  = hi_any ? hi_win : lo_win;
  assign any_req_o = |req_i;

endmodule

// File: rtl/rx_port_scheduler.sv
// Round-robin scheduler sharing one forwarding engine between NUM_PORTS ingress buffers.
module rx_port_scheduler
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned PORT_IDX_W     = port_idx_width(NUM_PORTS),
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TIMEOUT_W      = 13
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_PORTS-1:0]  port_enable,
  input  logic [NUM_PORTS-1:0]  buf_ready,
  output logic [NUM_PORTS-1:0]  buf_flush,
  output logic                  eng_start,
  output logic [PORT_IDX_W-1:0] eng_port,
  input  logic                  eng_done,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  state_e                 state_q;
  logic [PORT_IDX_W-1:0]  eng_port_q;
  logic [PORT_IDX_W-1:0]  last_grant_q;
  logic [TIMEOUT_W-1:0]   timer_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q;
  logic                   eng_start_q;
  logic [NUM_PORTS-1:0]   buf_flush_q;

  logic [NUM_PORTS-1:0]   req;
  logic [PORT_IDX_W-1:0]  winner;
  logic                   any_req;
  logic                   timer_max;

  assign req = buf_ready & port_enable;

  rr_arbiter #(
    .NUM_PORTS  (NUM_PORTS),
    .PORT_IDX_W (PORT_IDX_W)
  ) u_rr_arbiter (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .any_req_o    (any_req)
  );

  assign timer_max = (state_q == StWaitDone) && (timer_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      eng_port_q   <= '0;
      last_grant_q <= PORT_IDX_W'(NUM_PORTS - 1);
      timer_q      <= '0;
      drop_cnt_q   <= '0;
      eng_start_q  <= 1'b0;
      buf_flush_q  <= '0;
    end else begin
      eng_start_q <= 1'b0;
      buf_flush_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q      <= StGrant;
            eng_port_q   <= winner;
            last_grant_q <= winner;
            eng_start_q  <= 1'b1;
          end
        end
        StGrant: begin
          timer_q <= '0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (eng_done || timer_max) begin
            state_q     <= StFlush;
            buf_flush_q <= NUM_PORTS'(1) << eng_port_q;
            // Completion in the final cycle is not a drop.
            if (!eng_done && (drop_cnt_q != '1)) begin
              drop_cnt_q <= drop_cnt_q + 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StFlush:   state_q <= StRelease;
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign eng_start   = eng_start_q;
  assign eng_port    = eng_port_q;
  assign buf_flush   = buf_flush_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timer_max && !eng_done;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_rx_port_scheduler.sv
// Directed bench for rx_port_scheduler with a short timeout (8 cycles).
module tb_rx_port_scheduler;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  port_enable;
  logic [3:0]  buf_ready;
  logic [3:0]  buf_flush;
  logic        eng_start;
  logic [1:0]  eng_port;
  logic        eng_done;
  logic        busy;
  logic        timeout_err;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_start_cyc;

  rx_port_scheduler #(
    .NUM_PORTS      (4),
    .PORT_IDX_W     (2),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_W      (3)
  ) u_dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .port_enable (port_enable),
    .buf_ready   (buf_ready),
    .buf_flush   (buf_flush),
    .eng_start   (eng_start),
    .eng_port    (eng_port),
    .eng_done    (eng_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .drop_cnt    (drop_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
  endtask

  // Bounded wait for the next eng_start pulse.
  task automatic wait_start(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!eng_start && n < 20);
    check_eq(tag, 32'(eng_start), 32'd1);
  endtask

  logic [1:0] exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    aresetn     = 1'b0;
    port_enable = 4'b1111;
    buf_ready   = 4'b0000;
    eng_done    = 1'b0;
    #2;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(eng_start), 32'd0);
    check_eq("rst_flush", 32'(buf_flush), 32'd0);
    check_eq("rst_port", 32'(eng_port), 32'd0);
    check_eq("rst_tmo", 32'(timeout_err), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    step();
    aresetn = 1'b1;

    // 1: single packet on port 0, done on the third WAIT_DONE cycle.
    buf_ready = 4'b0001;
    step();
    check_eq("t1_start", 32'(eng_start), 32'd1);
    check_eq("t1_port", 32'(eng_port), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd1);
    step();
    check_eq("t1_start_pulse", 32'(eng_start), 32'd0);
    step();
    step();
    eng_done  = 1'b1;
    buf_ready = 4'b0000;
    step();
    eng_done = 1'b0;
    check_eq("t1_flush", 32'(buf_flush), 32'h1);
    check_eq("t1_busy_flush", 32'(busy), 32'd1);
    step();
    check_eq("t1_flush_pulse", 32'(buf_flush), 32'h0);
    check_eq("t1_busy_rel", 32'(busy), 32'd1);
    step();
    check_eq("t1_idle", 32'(busy), 32'd0);

    // 2: all ports ready, fastest completion -> 0,1,2,3,0 every 5 cycles.
    do_reset();
    buf_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start("t2_start");
      check_eq("t2_port", 32'(eng_port), 32'(exp_order[k]));
      if (k > 0) check_eq("t2_spacing", 32'(cyc - last_start_cyc), 32'd5);
      last_start_cyc = cyc;
      step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      check_eq("t2_flush", 32'(buf_flush), 32'(4'b0001 << exp_order[k]));
    end
    buf_ready = 4'b0000;
    step();
    step();

    // 3: three timeouts on port 0.
    do_reset();
    buf_ready = 4'b0001;
    for (int r = 0; r < 3; r++) begin
      wait_start("t3_start");
      for (int w = 1; w <= 8; w++) begin
        step();
        check_eq("t3_tmo", 32'(timeout_err), 32'(w == 8));
      end
      step();
      check_eq("t3_flush", 32'(buf_flush), 32'h1);
      check_eq("t3_tmo_off", 32'(timeout_err), 32'd0);
      check_eq("t3_drop", 32'(drop_cnt), 32'(r + 1));
    end

    // 4: done coincides with the last timer value -> no drop.
    wait_start("t4_start");
    repeat (8) step();
    check_eq("t4_tmo_pending", 32'(timeout_err), 32'd1);
    eng_done = 1'b1;
    #1;
    check_eq("t4_tmo_masked", 32'(timeout_err), 32'd0);
    step();
    eng_done = 1'b0;
    check_eq("t4_flush", 32'(buf_flush), 32'h1);
    check_eq("t4_drop", 32'(drop_cnt), 32'd3);
    buf_ready = 4'b0000;
    step();
    step();

    // 5: masked arbitration, then disable the granted port mid-packet.
    do_reset();
    port_enable = 4'b1011;
    buf_ready   = 4'b0110;
    wait_start("t5_start");
    check_eq("t5_port", 32'(eng_port), 32'd1);
    step();
    port_enable = 4'b1001;
    step();
    check_eq("t5_port_held", 32'(eng_port), 32'd1);
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check_eq("t5_flush", 32'(buf_flush), 32'h2);
    step();
    step();
    step();
    check_eq("t5_no_grant", 32'(busy), 32'd0);
    port_enable = 4'b1011;
    wait_start("t5_regrant");
    check_eq("t5_regrant_port", 32'(eng_port), 32'd1);
    step();
    eng_done = 1'b1;
    step();
    eng_done  = 1'b0;
    buf_ready = 4'b0000;
    port_enable = 4'b1111;
    step();
    step();

    // 6: async reset during WAIT_DONE, then port 2 wins first.
    buf_ready = 4'b0010;
    wait_start("t6_start");
    check_eq("t6_port", 32'(eng_port), 32'd1);
    step();
    step();
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("t6_async_busy", 32'(busy), 32'd0);
    check_eq("t6_async_port", 32'(eng_port), 32'd0);
    check_eq("t6_async_flush", 32'(buf_flush), 32'h0);
    buf_ready = 4'b0100;
    step();
    check_eq("t6_rst_flush", 32'(buf_flush), 32'h0);
    step();
    aresetn = 1'b1;
    wait_start("t6_restart");
    check_eq("t6_port2", 32'(eng_port), 32'd2);
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check_eq("t6_flush", 32'(buf_flush), 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
